// File: rtl/move_tick_gen.sv
// move_tick_gen: paces the alien formation by issuing a one-cycle `mueva` strobe
// whose period shrinks with the game level. Define MOVE_STEP_EN to add single-step while paused.
module move_tick_gen #(
  parameter int CNT_W       = 24,
  parameter int BASE_PERIOD = 2500000,
  parameter int STEP        = 150000,
  parameter int MIN_PERIOD  = 250000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [3:0]       level,
  input  logic             level_load,
  input  logic             pause_req,
`ifdef MOVE_STEP_EN
  input  logic             step,
`endif
  output logic             pause_ack,
  output logic             mueva,
  output logic [CNT_W-1:0] period_o,
  output logic [7:0]       move_count
);

  localparam int RW = CNT_W + 4;
  localparam logic [RW-1:0] SPAN = RW'(BASE_PERIOD - MIN_PERIOD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] period_reg, period_calc;
  logic [3:0]       level_q_reg;
  logic [RW-1:0]    red;
  logic             mueva_reg;
  logic             pause_ack_reg;
  logic [7:0]       move_count_reg;
  logic             fire;
`ifdef MOVE_STEP_EN
  logic             step_prev_reg;
`endif

  // Reduction is evaluated wide so a large level*STEP clamps to the floor instead of wrapping.
  always_comb begin
    red = RW'(level_q_reg) * RW'(STEP);
    if (red >= SPAN) begin
      period_calc = CNT_W'(MIN_PERIOD);
    end else begin
      period_calc = CNT_W'(RW'(BASE_PERIOD) - red);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    fire       = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (en) state_next = RUN;
      end
      RUN: begin
        if (!en) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (pause_req) begin
          state_next = PAUSED;
        end else if (cnt_reg >= period_reg - CNT_W'(1)) begin
          // >= rather than == so a period shortened below cnt fires at once
          cnt_next = '0;
          fire     = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      PAUSED: begin
        if (!en) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (!pause_req) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
`ifdef MOVE_STEP_EN
    if (state_reg == PAUSED && step && !step_prev_reg) fire = 1'b1;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      level_q_reg    <= '0;
      period_reg     <= CNT_W'(BASE_PERIOD);
      mueva_reg      <= 1'b0;
      pause_ack_reg  <= 1'b0;
      move_count_reg <= '0;
`ifdef MOVE_STEP_EN
      step_prev_reg  <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      period_reg    <= period_calc;
      mueva_reg     <= fire;
      pause_ack_reg <= (state_next == PAUSED);
      if (level_load) level_q_reg <= level;
      if (fire) move_count_reg <= move_count_reg + 8'd1;
`ifdef MOVE_STEP_EN
      step_prev_reg <= step;
`endif
    end
  end

  assign mueva      = mueva_reg;
  assign pause_ack  = pause_ack_reg;
  assign period_o   = period_reg;
  assign move_count = move_count_reg;

endmodule

// File: doc/move_tick_gen.md
Name: move_tick_gen

Overview:
- Pacing stage directly upstream of the alien-formation mover (Machine).
- Generates the single-cycle `mueva` move strobe that Machine consumes to step `posx`.
- Strobe period shrinks as the game level rises, so the formation speeds up.
- Supports a pause handshake with the game controller; counter state is frozen while paused.

Parameters:
- CNT_W, 24: width of period counter and period arithmetic.
- BASE_PERIOD, 2500000: strobe period in CLK cycles at level 0.
- STEP, 150000: period reduction per level.
- MIN_PERIOD, 250000: floor on period; must be >= 2.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- en  in  1  run enable from game controller.
- level  in  4  requested speed level.
- level_load  in  1  one-cycle strobe; latches `level`.
- pause_req  in  1  level-sensitive pause request.
- pause_ack  out  1  high while in PAUSED.
- mueva  out  1  one-cycle move strobe to Machine.
- period_o  out  CNT_W  currently applied period.
- move_count  out  8  number of strobes issued; wraps 255->0.

Behaviour:
- Reset (RST=1 at clock edge) forces:
  - state=IDLE, cnt=0, level_q=0
  - mueva=0, pause_ack=0, move_count=0
  - period_o=BASE_PERIOD
  - RST has priority over every other input.
- Period calculation:
  - red = level_q*STEP, computed at CNT_W+4 bits.
  - period = MIN_PERIOD if red >= BASE_PERIOD-MIN_PERIOD; else BASE_PERIOD-red.
  - Never underflows. Purely combinational from level_q; registered into period_o one cycle after level_q changes.
- level_load: level_q<=level on the strobe cycle, in any state. The new period_o applies from the following cycle.
- States:
  - IDLE:
    - cnt=0, mueva=0.
    - en=1 -> RUN.
  - RUN:
    - en=0 -> IDLE, clearing cnt.
    - Otherwise pause_req=1 -> PAUSED, holding cnt.
    - Otherwise, if cnt >= period_o-1: cnt<=0, mueva<=1 next cycle, move_count++.
    - Else cnt++.
  - PAUSED:
    - pause_ack=1 (registered; asserted the cycle after entry).
    - cnt frozen, mueva=0.
    - pause_req=0 -> RUN, resuming from the frozen cnt.
    - en=0 -> IDLE, with priority over pause release.
- Timing:
  - mueva is registered and high exactly one cycle per period.
  - First strobe occurs period_o cycles after the first RUN cycle.
  - Strobes are spaced exactly period_o cycles apart.
- Boundary conditions:
  - Period shrinks below cnt (level raised mid-period): the `>=` compare fires the strobe on the next RUN cycle. The counter never runs to wrap.
  - pause_req and the terminal count in the same cycle: pause wins. No strobe; cnt stays at the terminal value; the strobe fires on the first RUN cycle after release.
  - en=0 and pause_req=1 together: go to IDLE.
  - level_load in the same cycle as a strobe: the current strobe is unaffected.
  - move_count wraps silently.

Optional Feature:
- Macro: MOVE_STEP_EN.
- Defined:
  - Adds input port `step` (1 bit).
  - A rising edge of `step`, detected via a registered previous value, while in PAUSED produces exactly one mueva pulse on the next cycle and increments move_count.
  - cnt and state are unchanged.
  - Edges outside PAUSED are ignored.
- Undefined:
  - No `step` port.
  - PAUSED never emits mueva.

Test Plan:
- Bench parameters: CNT_W=8, BASE_PERIOD=10, STEP=2, MIN_PERIOD=4; CLK period 20 ns.
- Reset: RST=1 for 2 cycles mid-run -> mueva=0, pause_ack=0, move_count=0, period_o=10; remains IDLE while en=0.
- Base rate: en=1, level 0 -> first mueva 10 cycles after entering RUN, then every 10 cycles; move_count=3 after 30 RUN cycles.
- Level clamp: level_load with level=3 -> period_o=4; level=5 -> period_o=4 (10-10 clipped to MIN); level=15 -> 4, with no underflow.
- Mid-period speedup: at cnt=7, load level 3 -> mueva on the next RUN cycle, then every 4 cycles.
- Pause:
  - pause_req=1 at cnt=5 -> pause_ack=1 next cycle, no mueva for 20 cycles.
  - Release -> next mueva exactly 5 cycles later.
  - pause_req raised on the terminal-count cycle -> no strobe until the first cycle after release.
- Disable and step:
  - en=0 mid-period -> IDLE; on re-enable, full 10-cycle wait.
  - With MOVE_STEP_EN, two step edges while paused -> exactly two mueva pulses and move_count+2.
